led_message_scroller: RTL and testbench

Scroll controller that sequences the four-digit seven-segment display. Holds a nibble message buffer loaded over a valid/ready write port and presents a four-nibble window of it to the four-digit LED driver. When running, it advances the window by one position every `STEP_CYCLES` clocks, wrapping around the buffer. It sits between the control logic and the LED driver's digit inputs; anode multiplexing and segment decoding stay in the driver.

---
 rtl/led_message_scroller.sv | 145 ++++++++++++++
 tb/tb_led_message_scroller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_message_scroller.sv
// led_message_scroller: holds a nibble message buffer and scrolls a four-digit window
// across it for the seven-segment LED driver. The buffer is written over a valid/ready
// port while idle. A step counter advances the window pointer while running.
// All outputs are registered.
// Optional build macro: SCROLL_REVERSE_EN. It adds the `dir` input, which selects
// backward scrolling.
module led_message_scroller #(
    parameter int unsigned MSG_LEN     = 16,
    parameter int unsigned STEP_CYCLES = 25_000_000,
    parameter int unsigned AW          = $clog2(MSG_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic          start,
    input  logic          stop,
`ifdef SCROLL_REVERSE_EN
    input  logic          dir,
`endif
    output logic [3:0]    digit3,
    output logic [3:0]    digit2,
    output logic [3:0]    digit1,
    output logic [3:0]    digit0,
    output logic          busy,
    output logic          wrap_pulse
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(STEP_CYCLES - 1);
    localparam logic [AW-1:0] PtrLast = AW'(MSG_LEN - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    mem_q [MSG_LEN];
    logic [3:0]    mem_d [MSG_LEN];
    logic [15:0]   win_q, win_d;
    logic          wrap_evt_q, wrap_evt_d;
    logic          wrap_q, wrap_d;
    logic          busy_q, busy_d;
    logic          wr_ready_q, wr_ready_d;
    logic          step_back;

`ifdef SCROLL_REVERSE_EN
    assign step_back = dir;
`else
    assign step_back = 1'b0;
`endif

    // Next-state logic: writes and stop/start while idle; step counting while running.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        wrap_evt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_valid && wr_ready_q) begin
                    mem_d[wr_addr] = wr_data;
                end
                // stop wins over start, so start+stop together only rewinds.
                if (stop) begin
                    ptr_d = '0;
                end else if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (step_back) begin
                        ptr_d      = ptr_q - AW'(1);
                        wrap_evt_d = (ptr_q == '0);
                    end else begin
                        ptr_d      = ptr_q + AW'(1);
                        wrap_evt_d = (ptr_q == PtrLast);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next-state logic. The window is built from the current ptr/mem. The wrap
    // event is delayed one cycle so the pulse lines up with the wrapped digits.
    always_comb begin
        win_d = '0;
        for (int k = 0; k < 4; k++) begin
            win_d[15 - 4 * k -: 4] = mem_q[ptr_q + AW'(k)];
        end
        wrap_d     = wrap_evt_q;
        busy_d     = (state_d == StRun);
        wr_ready_d = (state_d == StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= '0;
            end
            win_q      <= '0;
            wrap_evt_q <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= mem_d[i];
            end
            win_q      <= win_d;
            wrap_evt_q <= wrap_evt_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign digit3     = win_q[15:12];
    assign digit2     = win_q[11:8];
    assign digit1     = win_q[7:4];
    assign digit0     = win_q[3:0];
    assign busy       = busy_q;
    assign wrap_pulse = wrap_q;
    assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_led_message_scroller.sv
// Testbench for led_message_scroller.
// Runs directed scenarios and a randomized run, checked against a behavioural model.
module tb_led_message_scroller;

    localparam int MSG_LEN = 16;
    localparam int STEP    = 8;

    logic       clk = 1'b0;
    logic       reset, wr_valid, start, stop;
    logic [3:0] wr_addr, wr_data;
    logic [3:0] d3, d2, d1, d0;
    logic       busy, wr_ready, wrap_pulse;
`ifdef SCROLL_REVERSE_EN
    logic       dir = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    logic [3:0]  m_mem [MSG_LEN];
    int          m_ptr;
    bit          m_run;
    int          m_cnt;
    bit          m_wrap_evt;
    logic [15:0] exp_dig;
    bit          exp_wrap;

    led_message_scroller #(.MSG_LEN(MSG_LEN), .STEP_CYCLES(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
`ifdef SCROLL_REVERSE_EN
        .dir       (dir),
`endif
        .digit3    (d3),
        .digit2    (d2),
        .digit1    (d1),
        .digit0    (d0),
        .busy      (busy),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] window(int p);
        logic [15:0] w;
        for (int k = 0; k < 4; k++) w[15 - 4 * k -: 4] = m_mem[(p + k) % MSG_LEN];
        return w;
    endfunction

    task automatic set_idle();
        reset = 1'b0; wr_valid = 1'b0; start = 1'b0; stop = 1'b0;
        wr_addr = 4'h0; wr_data = 4'h0;
    endtask

    // One clock: apply the model's rules to the inputs seen at the edge, then check outputs.
    task automatic cycle();
        bit back;
        back = 1'b0;
`ifdef SCROLL_REVERSE_EN
        back = dir;
`endif
        @(posedge clk);
        exp_dig    = window(m_ptr);
        exp_wrap   = m_wrap_evt;
        m_wrap_evt = 1'b0;
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) m_mem[i] = 4'h0;
            m_ptr = 0; m_run = 1'b0; m_cnt = 0;
            exp_dig = 16'h0; exp_wrap = 1'b0;
        end else if (!m_run) begin
            if (wr_valid) m_mem[wr_addr] = wr_data;
            if (stop) m_ptr = 0;
            else if (start) begin m_run = 1'b1; m_cnt = 0; end
        end else begin
            if (stop) begin
                m_run = 1'b0; m_cnt = 0;
            end else if (m_cnt == STEP - 1) begin
                m_cnt = 0;
                if (back) begin
                    m_wrap_evt = (m_ptr == 0);
                    m_ptr = (m_ptr + MSG_LEN - 1) % MSG_LEN;
                end else begin
                    m_wrap_evt = (m_ptr == MSG_LEN - 1);
                    m_ptr = (m_ptr + 1) % MSG_LEN;
                end
            end else begin
                m_cnt++;
            end
        end
        #1;
        n_cmp++;
        if ({d3, d2, d1, d0} !== exp_dig) begin
            n_bad++;
            $display("FAIL digits @%0t: got %h expected %h", $time, {d3, d2, d1, d0}, exp_dig);
        end
        n_cmp++;
        if ({busy, wr_ready, wrap_pulse} !== {m_run, !m_run, exp_wrap}) begin
            n_bad++;
            $display("FAIL status(busy,wr_ready,wrap) @%0t: got %b%b%b expected %b%b%b",
                     $time, busy, wr_ready, wrap_pulse, m_run, !m_run, exp_wrap);
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        n_cmp++;
        if ({d3, d2, d1, d0, busy, wr_ready, wrap_pulse} !== {16'h0, 3'b010}) begin
            n_bad++;
            $display("FAIL reset_state: got %h %b%b%b expected 0000 010",
                     {d3, d2, d1, d0}, busy, wr_ready, wrap_pulse);
        end
    endtask

    task automatic test_write_all();
        for (int i = 0; i < MSG_LEN; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
            cycle();
        end
        set_idle();
        repeat (STEP + 3) cycle();
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h0123) begin
            n_bad++;
            $display("FAIL write_all_window: got %h expected 0123", {d3, d2, d1, d0});
        end
    endtask

    task automatic test_scroll();
        start = 1'b1;
        cycle();  // E0
        start = 1'b0;
        // Writes during RUN must be ignored; address 1 is visible after the first step.
        wr_valid = 1'b1; wr_addr = 4'h1; wr_data = 4'hF;
        repeat (9) cycle();
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h1234) begin
            n_bad++;
            $display("FAIL scroll_step1: got %h expected 1234", {d3, d2, d1, d0});
        end
        wr_addr = 4'h5; wr_data = 4'h0;
        repeat (8) cycle();
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h2345) begin
            n_bad++;
            $display("FAIL scroll_step2: got %h expected 2345", {d3, d2, d1, d0});
        end
        set_idle();
    endtask

    task automatic test_wrap();
        bit seen_ef01 = 1'b0;
        bit wrap_on_0123 = 1'b0;
        int wrap_cnt = 0;
        for (int i = 0; i < 20 * STEP; i++) begin
            cycle();
            if ({d3, d2, d1, d0} === 16'hEF01) seen_ef01 = 1'b1;
            if (wrap_pulse === 1'b1) begin
                wrap_cnt++;
                if ({d3, d2, d1, d0} === 16'h0123) wrap_on_0123 = 1'b1;
            end
        end
        n_cmp++;
        if (!seen_ef01) begin
            n_bad++;
            $display("FAIL wrap_window_ef01: got not-seen expected seen");
        end
        n_cmp++;
        if (wrap_cnt != 1 || !wrap_on_0123) begin
            n_bad++;
            $display("FAIL wrap_pulse: got count %0d aligned %0b expected count 1 aligned 1",
                     wrap_cnt, wrap_on_0123);
        end
    endtask

    task automatic test_stop_terminal();
        int          saved;
        logic [15:0] frozen;
        int          guard = 0;
        while (m_cnt != STEP - 1 && guard < 4 * STEP) begin
            cycle();
            guard++;
        end
        n_cmp++;
        if (m_cnt != STEP - 1) begin
            n_bad++;
            $display("FAIL terminal_reach: got cnt %0d expected %0d", m_cnt, STEP - 1);
        end
        saved = m_ptr;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (STEP + 2) cycle();
        frozen = window(saved);
        n_cmp++;
        if ({d3, d2, d1, d0, busy} !== {frozen, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_on_terminal: got %h busy %b expected %h busy 0",
                     {d3, d2, d1, d0}, busy, frozen);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (STEP + 1) cycle();
        frozen = window((saved + 1) % MSG_LEN);
        n_cmp++;
        if ({d3, d2, d1, d0} !== frozen) begin
            n_bad++;
            $display("FAIL resume_from_frozen: got %h expected %h", {d3, d2, d1, d0}, frozen);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_start_stop_same();
        start = 1'b1; stop = 1'b1;
        cycle();
        set_idle();
        cycle();
        n_cmp++;
        if ({d3, d2, d1, d0, busy, wr_ready} !== {16'h0123, 2'b01}) begin
            n_bad++;
            $display("FAIL start_stop_same: got %h busy %b rdy %b expected 0123 busy 0 rdy 1",
                     {d3, d2, d1, d0}, busy, wr_ready);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (STEP + 3) cycle();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        n_cmp++;
        if ({d3, d2, d1, d0, busy, wr_ready} !== {16'h0, 2'b01}) begin
            n_bad++;
            $display("FAIL reset_midrun: got %h busy %b rdy %b expected 0000 busy 0 rdy 1",
                     {d3, d2, d1, d0}, busy, wr_ready);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (STEP + 1) cycle();
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h0) begin
            n_bad++;
            $display("FAIL buffer_cleared: got %h expected 0000", {d3, d2, d1, d0});
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 999) == 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 59) == 0);
`ifdef SCROLL_REVERSE_EN
            dir      = ($urandom_range(0, 1) == 1);
`endif
            cycle();
        end
        set_idle();
`ifdef SCROLL_REVERSE_EN
        dir = 1'b0;
`endif
    endtask

`ifdef SCROLL_REVERSE_EN
    task automatic test_reverse();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
            cycle();
        end
        set_idle();
        dir = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (9) cycle();
        n_cmp++;
        if ({d3, d2, d1, d0, wrap_pulse} !== {16'hF012, 1'b1}) begin
            n_bad++;
            $display("FAIL reverse_step: got %h wrap %b expected F012 wrap 1",
                     {d3, d2, d1, d0}, wrap_pulse);
        end
        dir = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < MSG_LEN; i++) m_mem[i] = 4'h0;
        m_ptr = 0; m_run = 1'b0; m_cnt = 0; m_wrap_evt = 1'b0;
        test_reset();
        test_write_all();
        test_scroll();
        test_wrap();
        test_stop_terminal();
        test_start_stop_same();
        test_reset_midrun();
        test_random();
`ifdef SCROLL_REVERSE_EN
        test_reverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
